hangman_ctrl: RTL and testbench

HANGMAN_CTRL -- requirements
Module: hangman_ctrl

---
 rtl/hangman_pkg.sv | 24 ++
 rtl/hangman_frame_latch.sv | 43 ++++
 rtl/hangman_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hangman_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman controller: FSM state encoding,
// display codes and letter code width.
package hangman_pkg;
  localparam int CODE_W      = 5;
  localparam int NUM_LETTERS = 26;

  localparam logic [CODE_W-1:0] CODE_QMARK = 5'd26;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_EVAL  = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_e;

  // Stored codes above the alphabet are spaces and never need guessing.
  function automatic logic is_space(input logic [CODE_W-1:0] c);
    return c >= CODE_W'(NUM_LETTERS);
  endfunction
endpackage

// File: rtl/hangman_frame_latch.sv
// frame_latch: registers vsync, detects its falling edge and holds the
// displayed slot codes so the picture only changes between frames.
module frame_latch
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = 10
) (
  input  logic                              dclk,
  input  logic                              clr_n,
  input  logic                              vsync,
  input  logic [WORD_LEN-1:0][CODE_W-1:0]   live_code,
  output logic [CODE_W*WORD_LEN-1:0]        slot_code
);
  logic vs_q, vs_prev_q, fall;
  logic [WORD_LEN-1:0][CODE_W-1:0] code_q, code_d;

  // vsync is idle-high; two stages give a registered copy and its history.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_q      <= vsync;
      vs_prev_q <= vs_q;
    end
  end

  assign fall = vs_prev_q & ~vs_q;

  // Capture live codes only on a frame boundary.
  always_comb begin
    code_d = code_q;
    if (fall) code_d = live_code;
  end

  // Shadow register shows blanks out of reset.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) code_q <= {WORD_LEN{CODE_BLANK}};
    else        code_q <= code_d;
  end

  assign slot_code = code_q;
endmodule

// File: rtl/hangman_ctrl.sv
// hangman_ctrl: word load, guess handling and slot-by-slot letter compare.
// Optional feature: define HANGMAN_REVEAL_ON_LOSE_EN to show the whole word
// once the game is lost.
module hangman_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = 10,
  parameter int MAX_MISS = 6
) (
  input  logic                       dclk,
  input  logic                       clr_n,
  input  logic                       new_game,
  input  logic                       word_wr,
  input  logic [CODE_W-1:0]          word_char,
  input  logic                       guess_valid,
  input  logic [CODE_W-1:0]          guess_letter,
  output logic                       guess_ready,
  input  logic                       vsync,
  output logic [CODE_W*WORD_LEN-1:0] slot_code,
  output logic [2:0]                 miss_cnt,
  output logic [2:0]                 state_o,
  output logic                       win,
  output logic                       lose
);
  localparam int               IDX_W      = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_LEN - 1);
  localparam logic [2:0]       MISS_LIMIT = 3'(MAX_MISS);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [WORD_LEN-1:0][CODE_W-1:0] word_q, word_d;
  logic [WORD_LEN-1:0]             rev_q, rev_d;
  logic [NUM_LETTERS-1:0]          used_q, used_d;
  logic [2:0]                      miss_q, miss_d;
  logic [CODE_W-1:0]               guess_q, guess_d;
  logic                            hit_q, hit_d;
  logic [WORD_LEN-1:0]             space_m;
  logic [WORD_LEN-1:0][CODE_W-1:0] live_code;

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_space
    assign space_m[i] = is_space(word_q[i]);
  end

  // Next-state: new_game overrides everything; CHECK walks one slot per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rev_d   = rev_q;
    used_d  = used_q;
    miss_d  = miss_q;
    guess_d = guess_q;
    hit_d   = hit_q;
    if (new_game) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      rev_d   = '0;
      used_d  = '0;
      miss_d  = '0;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (word_wr) begin
          word_d[0] = word_char;
          idx_d     = IDX_W'(1);
          state_d   = (WORD_LEN == 1) ? ST_PLAY : ST_LOAD;
        end
        ST_LOAD: if (word_wr) begin
          word_d[idx_q] = word_char;
          if (idx_q == LAST_IDX) begin
            state_d = ST_PLAY;
            idx_d   = '0;
            rev_d   = '0;
            used_d  = '0;
            miss_d  = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_PLAY: if (guess_valid && guess_letter < CODE_W'(NUM_LETTERS)
                     && !used_q[guess_letter]) begin
          used_d[guess_letter] = 1'b1;
          guess_d = guess_letter;
          idx_d   = '0;
          hit_d   = 1'b0;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (word_q[idx_q] == guess_q) begin
            rev_d[idx_q] = 1'b1;
            hit_d        = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_EVAL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_EVAL: begin
          if (hit_q) begin
            state_d = (&(rev_q | space_m)) ? ST_WIN : ST_PLAY;
          end else begin
            miss_d  = miss_q + 3'd1;
            state_d = (miss_d == MISS_LIMIT) ? ST_LOSE : ST_PLAY;
          end
        end
        default: ; // WIN and LOSE hold until new_game
      endcase
    end
  end

  // Controller state; reset aborts any load or compare in progress.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      rev_q   <= '0;
      used_q  <= '0;
      miss_q  <= '0;
      guess_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      rev_q   <= rev_d;
      used_q  <= used_d;
      miss_q  <= miss_d;
      guess_q <= guess_d;
      hit_q   <= hit_d;
    end
  end

  // Live display code per slot, before frame latching.
  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      live_code[i] = CODE_QMARK;
      if (state_q == ST_IDLE || state_q == ST_LOAD) live_code[i] = CODE_BLANK;
      else if (rev_q[i] || space_m[i])               live_code[i] = word_q[i];
`ifdef HANGMAN_REVEAL_ON_LOSE_EN
      else if (state_q == ST_LOSE)                   live_code[i] = word_q[i];
`else
      else                                           live_code[i] = CODE_QMARK;
`endif
    end
  end

  frame_latch #(.WORD_LEN(WORD_LEN)) u_frame (
    .dclk      (dclk),
    .clr_n     (clr_n),
    .vsync     (vsync),
    .live_code (live_code),
    .slot_code (slot_code)
  );

  assign guess_ready = (state_q == ST_PLAY);
  assign win         = (state_q == ST_WIN);
  assign lose        = (state_q == ST_LOSE);
  assign state_o     = state_q;
  assign miss_cnt    = miss_q;
endmodule

// File: tb/tb_hangman_ctrl.sv
// Self-checking bench for hangman_ctrl: directed scenarios plus random games
// compared against a letter-set model of the game rules.
module tb_hangman_ctrl;
  localparam int WL = 10;
  localparam int MM = 6;

  logic dclk = 1'b0, clr_n = 1'b0, new_game = 1'b0, word_wr = 1'b0;
  logic guess_valid = 1'b0, vsync = 1'b1;
  logic [4:0] word_char = '0, guess_letter = '0;
  logic guess_ready, win, lose;
  logic [2:0] miss_cnt, state_o;
  logic [5*WL-1:0] slot_code;

  int checks = 0, errors = 0;

  // Reference model: the word, the set of guessed letters, misses, game phase
  // (0 idle, 1 load, 2 play, 5 win, 6 lose) and what the screen should show.
  logic [4:0] mword [WL];
  bit         mused [26];
  int         mmiss, mstate;
  logic [5*WL-1:0] shown;
  logic [4:0] hw [WL] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd22, 5'd14, 5'd17, 5'd11, 5'd3};

  hangman_ctrl #(.WORD_LEN(WL), .MAX_MISS(MM)) dut (
    .dclk(dclk), .clr_n(clr_n), .new_game(new_game), .word_wr(word_wr),
    .word_char(word_char), .guess_valid(guess_valid), .guess_letter(guess_letter),
    .guess_ready(guess_ready), .vsync(vsync), .slot_code(slot_code),
    .miss_cnt(miss_cnt), .state_o(state_o), .win(win), .lose(lose));

  always #20 dclk = ~dclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge dclk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5*WL-1:0] exp_codes();
    logic [5*WL-1:0] r;
    logic [4:0] c;
    r = '0;
    for (int i = 0; i < WL; i++) begin
      if (mstate <= 1)                       c = 5'd27;
      else if (mword[i] >= 26 || mused[mword[i]]) c = mword[i];
      else                                   c = 5'd26;
`ifdef HANGMAN_REVEAL_ON_LOSE_EN
      if (mstate == 6) c = mword[i];
`endif
      r[5*i +: 5] = c;
    end
    return r;
  endfunction

  function automatic void model_clear();
    mstate = 0;
    mmiss  = 0;
    for (int i = 0; i < 26; i++) mused[i] = 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, state_o, mstate);
    chk({tag, ".miss"},  miss_cnt, mmiss);
    chk({tag, ".win"},   win,  mstate == 5);
    chk({tag, ".lose"},  lose, mstate == 6);
    chk({tag, ".ready"}, guess_ready, mstate == 2);
    chk({tag, ".held"},  slot_code, shown);
  endtask

  task automatic vsync_frame(input string tag);
    vsync = 1'b0;
    tick; tick; tick;
    vsync = 1'b1;
    tick;
    shown = exp_codes();
    chk({tag, ".slots"}, slot_code, shown);
  endtask

  task automatic load_word(input string tag);
    for (int i = 0; i < WL; i++) begin
      word_wr = 1'b1; word_char = mword[i];
      tick;
      chk({tag, ".ld_state"}, state_o, (i == WL-1) ? 2 : 1);
    end
    word_wr = 1'b0;
    model_clear();
    mstate = 2;
  endtask

  task automatic pulse_new_game(input string tag);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    model_clear();
    check_outputs(tag);
  endtask

  task automatic guess(input logic [4:0] g, input string tag);
    int cnt;
    bit hit, all_rev;
    guess_valid = 1'b1; guess_letter = g;
    tick;
    guess_valid = 1'b0;
    if (mstate != 2 || g > 25 || mused[g]) begin
      check_outputs(tag);   // refused or ignored: nothing changes
      return;
    end
    cnt = 1;
    while ((state_o == 3'd3 || state_o == 3'd4) && cnt < 40) begin
      tick; cnt++;
    end
    chk({tag, ".gap"}, cnt, WL + 2);
    mused[g] = 1'b1;
    hit = 1'b0; all_rev = 1'b1;
    for (int i = 0; i < WL; i++) begin
      if (mword[i] == g) hit = 1'b1;
      if (!(mword[i] >= 26 || mused[mword[i]])) all_rev = 1'b0;
    end
    if (hit) mstate = all_rev ? 5 : 2;
    else begin
      mmiss++;
      mstate = (mmiss == MM) ? 6 : 2;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [4:0] g;
    int n;
    // Reset state
    model_clear();
    shown = {WL{5'd27}};
    tick; tick;
    check_outputs("reset");
    clr_n = 1'b1;
    tick;

    // HELLOWORLD load and first frame
    mword = hw;
    load_word("load1");
    vsync_frame("frame_play");

    // Hit on L: the picture must not change until vsync
    guess(5'd11, "guess_L");
    vsync_frame("frame_L");
    chk("slot2_L", slot_code[14:10], 5'd11);
    chk("slot8_L", slot_code[44:40], 5'd11);

    // Repeat and out-of-range guesses are ignored
    guess(5'd11, "guess_L_again");
    guess(5'd31, "guess_31");

    // Six misses end in LOSE
    guess(5'd0, "miss_A"); guess(5'd1, "miss_B"); guess(5'd2, "miss_C");
    guess(5'd5, "miss_F"); guess(5'd6, "miss_G"); guess(5'd8, "miss_I");
    vsync_frame("frame_lose");
    guess(5'd4, "after_lose");

    // Back to IDLE shows blanks
    pulse_new_game("ng_lose");
    vsync_frame("frame_idle");

    // Winning game with one miss along the way
    mword = hw;
    load_word("load2");
    guess(5'd7, "w_H");  guess(5'd4, "w_E");  guess(5'd9, "w_miss");
    guess(5'd11, "w_L"); guess(5'd14, "w_O"); guess(5'd22, "w_W");
    guess(5'd17, "w_R"); guess(5'd3, "w_D");
    chk("win_state", state_o, 3'd5);
    guess(5'd0, "after_win");
    vsync_frame("frame_win");

    // new_game in the middle of CHECK
    pulse_new_game("ng_win");
    mword = hw;
    load_word("load3");
    guess(5'd0, "pre_miss");
    guess_valid = 1'b1; guess_letter = 5'd7;
    tick;
    guess_valid = 1'b0;
    tick; tick;
    chk("mid_check", state_o, 3'd3);
    pulse_new_game("ng_check");
    mword = hw;
    load_word("load4");
    vsync_frame("frame_after_abort");
    guess(5'd7, "reguess_H");

    // Reset in the middle of LOAD
    pulse_new_game("ng_pre_load");
    for (int i = 0; i < 4; i++) begin
      word_wr = 1'b1; word_char = hw[i];
      tick;
    end
    word_wr = 1'b0;
    clr_n = 1'b0;
    #1;
    model_clear();
    shown = {WL{5'd27}};
    check_outputs("rst_in_load");
    tick;
    clr_n = 1'b1;
    tick;
    check_outputs("rst_released");
    mword = hw;
    load_word("load5");
    vsync_frame("frame_load5");

    // Random games
    for (int game = 0; game < 4; game++) begin
      pulse_new_game("rnd_ng");
      for (int i = 0; i < WL; i++)
        mword[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(26, 31))
                                               : 5'($urandom_range(0, 25));
      load_word("rnd_load");
      vsync_frame("rnd_frame0");
      n = 0;
      while (mstate == 2 && n < 60) begin
        if ($urandom_range(0, 1) == 1) g = mword[$urandom_range(0, WL-1)];
        else                            g = 5'($urandom_range(0, 31));
        guess(g, "rnd_guess");
        n++;
        if (n % 4 == 0) vsync_frame("rnd_frame");
      end
      vsync_frame("rnd_end");
      guess(5'($urandom_range(0, 25)), "rnd_after_end");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
